// File: rtl/pipe_ctrl.sv
// Stall merger and multi-cycle EX sequencer (MACC, iterative divide with watchdog).
// stall_en is combinational; the FSM keeps running under a MEM stall; flush drops any sequence.
module pipe_ctrl #(
    parameter int DIV_MAX = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       id_stall_req,
    input  logic       mem_stall_req,
    input  logic       ex_mc_req,
    input  logic       ex_mc_type,
    input  logic       div_zero,
    input  logic       div_done,
    output logic [5:0] stall_en,
    output logic       div_start,
    output logic       ex_phase,
    output logic       ex_mc_done,
    output logic       div_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MACC     = 2'd1,
        DIV_WAIT = 2'd2,
        DIV_END  = 2'd3
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(DIV_MAX - 1);

    state_t     state, state_nxt;
    logic [5:0] div_cnt, div_cnt_nxt;
    logic       abort, abort_nxt;
    logic       ex_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= 6'd0;
            abort   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            abort   <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        abort_nxt   = abort;
        ex_stall    = 1'b0;
        div_start   = 1'b0;
        ex_phase    = 1'b0;
        ex_mc_done  = 1'b0;
        div_err     = 1'b0;
        stall_en    = 6'b000000;

        case (state)
            IDLE: begin
                if (ex_mc_req) begin
                    ex_stall = 1'b1;
                    if (!ex_mc_type) begin
                        state_nxt = MACC;
                    end else begin
                        // A zero divisor skips the divider entirely.
                        state_nxt   = div_zero ? DIV_END : DIV_WAIT;
                        div_cnt_nxt = 6'd0;
                        abort_nxt   = 1'b0;
                    end
                end
            end
            MACC: begin
                ex_phase   = 1'b1;
                ex_mc_done = 1'b1;
                state_nxt  = IDLE;
            end
            DIV_WAIT: begin
                div_start   = 1'b1;
                ex_stall    = 1'b1;
                div_cnt_nxt = div_cnt + 6'd1;
                if (div_done) begin
                    state_nxt = DIV_END;
                end else if (div_cnt == CNT_LAST) begin
                    state_nxt = DIV_END;
                    abort_nxt = 1'b1;
                end
            end
            default: begin
                ex_mc_done = 1'b1;
                div_err    = abort;
                state_nxt  = IDLE;
                abort_nxt  = 1'b0;
            end
        endcase

        if (flush) begin
            state_nxt   = IDLE;
            div_cnt_nxt = 6'd0;
            abort_nxt   = 1'b0;
            div_start   = 1'b0;
            ex_phase    = 1'b0;
            ex_mc_done  = 1'b0;
            div_err     = 1'b0;
        end else if (mem_stall_req) begin
            stall_en = 6'b011111;
        end else if (ex_stall) begin
            stall_en = 6'b001111;
        end else if (id_stall_req) begin
            stall_en = 6'b000111;
        end

        // Outputs are silent for as long as reset is held, independent of the clock.
        if (reset) begin
            stall_en   = 6'b000000;
            div_start  = 1'b0;
            ex_phase   = 1'b0;
            ex_mc_done = 1'b0;
            div_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed stimulus against a cycle-level reference model, checked via a scoreboard queue.
module tb_pipe_ctrl;

    localparam int DIV_MAX = 8;

    logic       clk = 1'b0;
    logic       reset, flush, id_stall_req, mem_stall_req;
    logic       ex_mc_req, ex_mc_type, div_zero, div_done;
    logic [5:0] stall_en;
    logic       div_start, ex_phase, ex_mc_done, div_err;

    pipe_ctrl #(.DIV_MAX(DIV_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .id_stall_req (id_stall_req),
        .mem_stall_req(mem_stall_req),
        .ex_mc_req    (ex_mc_req),
        .ex_mc_type   (ex_mc_type),
        .div_zero     (div_zero),
        .div_done     (div_done),
        .stall_en     (stall_en),
        .div_start    (div_start),
        .ex_phase     (ex_phase),
        .ex_mc_done   (ex_mc_done),
        .div_err      (div_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];
    bit stim_done = 1'b0;

    // Model of the op in flight: 0 none, 1 MACC second cycle, 2 waiting on divider, 3 finishing.
    int m_kind = 0;
    int m_elapsed = 0;
    bit m_abort = 1'b0;

    function automatic logic [9:0] outs();
        return {stall_en, div_start, ex_phase, ex_mc_done, div_err};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    function automatic logic [9:0] model_out();
        logic [5:0] st;
        bit ex_st, st_start, st_phase, st_done, st_err;
        if (reset) return 10'd0;
        ex_st    = (m_kind == 0 && ex_mc_req) || m_kind == 2;
        st_start = (m_kind == 2);
        st_phase = (m_kind == 1);
        st_done  = (m_kind == 1) || (m_kind == 3);
        st_err   = (m_kind == 3) && m_abort;
        if (flush) begin
            st_start = 0; st_phase = 0; st_done = 0; st_err = 0;
            st = 6'b000000;
        end else if (mem_stall_req) st = 6'b011111;
        else if (ex_st)             st = 6'b001111;
        else if (id_stall_req)      st = 6'b000111;
        else                        st = 6'b000000;
        return {st, st_start, st_phase, st_done, st_err};
    endfunction

    task automatic model_step();
        if (reset || flush) begin
            m_kind = 0; m_elapsed = 0; m_abort = 0;
        end else begin
            case (m_kind)
                0: if (ex_mc_req) begin
                    if (!ex_mc_type) m_kind = 1;
                    else begin
                        m_kind = div_zero ? 3 : 2;
                        m_elapsed = 0;
                        m_abort = 0;
                    end
                end
                1: m_kind = 0;
                2: begin
                    m_elapsed++;
                    if (div_done) m_kind = 3;
                    else if (m_elapsed == DIV_MAX) begin
                        m_kind = 3;
                        m_abort = 1;
                    end
                end
                default: begin
                    m_kind = 0;
                    m_abort = 0;
                end
            endcase
        end
    endtask

    // One cycle: advance the model over the inputs just sampled, then apply new inputs.
    task automatic cyc(input bit r, input bit fl, input bit id, input bit mem,
                       input bit rq, input bit ty, input bit z, input bit dn);
        @(posedge clk);
        #1;
        model_step();
        reset = r; flush = fl; id_stall_req = id; mem_stall_req = mem;
        ex_mc_req = rq; ex_mc_type = ty; div_zero = z; div_done = dn;
        #1;
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle_outputs", outs(), exp_q.pop_front());
    end

    initial begin
        reset = 1; flush = 0; id_stall_req = 1; mem_stall_req = 0;
        ex_mc_req = 1; ex_mc_type = 0; div_zero = 0; div_done = 0;
        #2;
        check("reset_outputs", outs(), 10'd0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 1, 0, 0, 0);
        idle(3);

        // MACC with request held into the done cycle: no re-trigger.
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // DIV with done in the 5th wait cycle.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(0, 0, 0, 0, 0, 0, 0, k == 5);
        idle(2);

        // Divide by zero, then a stray div_done while idle.
        cyc(0, 0, 0, 0, 1, 1, 1, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Silent divider trips the watchdog.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        idle(DIV_MAX + 3);

        // Stall priority ladder.
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 1, 1, 0, 0);
        idle(2);

        // Flush in the 3rd wait cycle, then a fresh silent DIV must take the full watchdog span.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        idle(DIV_MAX + 3);

        // Asynchronous reset in the middle of DIV_WAIT.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        idle(2);
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        check("async_reset", outs(), 10'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end
        idle(2);
        @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done == 1'b1);
            #2_000_000;
        join_any
        if (!stim_done) begin
            n_checks++;
            $display("FAIL timeout: stimulus did not complete, got incomplete expected complete");
        end
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
